// File: rtl/cdb_arbiter_if.sv
// Result-port and broadcast bundle between the functional units and the CDB arbiter.
// The master side is the FU cluster and downstream listeners; the slave side is the arbiter.
interface cdb_arbiter_if #(
    parameter int NUM_FU     = 4,
    parameter int DATA_WIDTH = 32
);
    logic                         flush_in;
    logic [NUM_FU-1:0]            fu_valid_in;
    logic [NUM_FU-1:0]            fu_ready_out;
    logic [NUM_FU*8-1:0]          fu_tag_in;
    logic [NUM_FU*DATA_WIDTH-1:0] fu_value_in;
    logic [NUM_FU-1:0]            fu_mispredicted_in;
    logic [7:0]                   cdb1_tag_out;
    logic [DATA_WIDTH-1:0]        cdb1_value_out;
    logic                         cdb1_mispredicted_out;
    logic [7:0]                   cdb2_tag_out;
    logic [DATA_WIDTH-1:0]        cdb2_value_out;
    logic                         cdb2_mispredicted_out;

    modport master (
        output flush_in, fu_valid_in, fu_tag_in, fu_value_in, fu_mispredicted_in,
        input  fu_ready_out,
        input  cdb1_tag_out, cdb1_value_out, cdb1_mispredicted_out,
        input  cdb2_tag_out, cdb2_value_out, cdb2_mispredicted_out
    );

    modport slave (
        input  flush_in, fu_valid_in, fu_tag_in, fu_value_in, fu_mispredicted_in,
        output fu_ready_out,
        output cdb1_tag_out, cdb1_value_out, cdb1_mispredicted_out,
        output cdb2_tag_out, cdb2_value_out, cdb2_mispredicted_out
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Common-data-bus transmit arbiter: per-FU result FIFOs feeding two registered broadcast
// slots, granted round-robin so every functional unit makes progress.
module cdb_arbiter #(
    parameter int         NUM_FU     = 4,
    parameter int         QDEPTH     = 2,
    parameter int         DATA_WIDTH = 32,
    parameter logic [7:0] RSTAG_NULL = 8'hFF
) (
    input logic          clock,
    input logic          reset,
    cdb_arbiter_if.slave bus
);
    localparam int RW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam int PW = $clog2(QDEPTH);
    localparam logic [RW:0] FU_CNT = (RW + 1)'(NUM_FU);
    localparam logic [RW:0] ONE_W  = (RW + 1)'(1);

    typedef logic [RW-1:0] fu_idx_t;
    typedef logic [PW-1:0] qptr_t;
    typedef logic [PW:0]   qcnt_t;

    logic [7:0]            tag_mem   [NUM_FU][QDEPTH];
    logic [DATA_WIDTH-1:0] value_mem [NUM_FU][QDEPTH];
    logic                  misp_mem  [NUM_FU][QDEPTH];

    qptr_t             rd_ptr [NUM_FU];
    qptr_t             wr_ptr [NUM_FU];
    qcnt_t             count  [NUM_FU];
    fu_idx_t           rr_ptr;
    fu_idx_t           rr_next;
    logic [NUM_FU-1:0] ready;
    logic [NUM_FU-1:0] nonempty;
    logic [NUM_FU-1:0] push;
    logic [NUM_FU-1:0] pop;
    logic              vld1_p0;
    logic              vld2_p0;
    fu_idx_t           idx1_p0;
    fu_idx_t           idx2_p0;

    function automatic fu_idx_t wrap_idx(input logic [RW:0] sum);
        return fu_idx_t'((sum >= FU_CNT) ? (sum - FU_CNT) : sum);
    endfunction

    // Stage p0: FIFO status, accept and round-robin grant from registered occupancy only
    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            ready[i]    = (count[i] != qcnt_t'(QDEPTH));
            nonempty[i] = (count[i] != '0);
            push[i]     = bus.fu_valid_in[i] & ready[i] & ~bus.flush_in;
        end
    end

    assign bus.fu_ready_out = ready;

    always_comb begin
        fu_idx_t c;
        c       = '0;
        vld1_p0 = 1'b0;
        vld2_p0 = 1'b0;
        idx1_p0 = '0;
        idx2_p0 = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            c = wrap_idx({1'b0, rr_ptr} + (RW + 1)'(k));
            if (nonempty[c]) begin
                if (!vld1_p0) begin
                    vld1_p0 = 1'b1;
                    idx1_p0 = c;
                end else if (!vld2_p0) begin
                    vld2_p0 = 1'b1;
                    idx2_p0 = c;
                end
            end
        end
        pop = '0;
        if (vld1_p0) pop[idx1_p0] = 1'b1;
        if (vld2_p0) pop[idx2_p0] = 1'b1;
        rr_next = rr_ptr;
        if (vld2_p0)      rr_next = wrap_idx({1'b0, idx2_p0} + ONE_W);
        else if (vld1_p0) rr_next = wrap_idx({1'b0, idx1_p0} + ONE_W);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_ptr <= '0;
            for (int i = 0; i < NUM_FU; i++) begin
                count[i]  <= '0;
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
            end
        end else if (bus.flush_in) begin
            rr_ptr <= '0;
            for (int i = 0; i < NUM_FU; i++) begin
                count[i]  <= '0;
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
            end
        end else begin
            rr_ptr <= rr_next;
            for (int i = 0; i < NUM_FU; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + qptr_t'(1);
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + qptr_t'(1);
                case ({push[i], pop[i]})
                    2'b10:   count[i] <= count[i] + qcnt_t'(1);
                    2'b01:   count[i] <= count[i] - qcnt_t'(1);
                    default: count[i] <= count[i];
                endcase
            end
        end
    end

    // FIFO storage carries no reset; occupancy alone decides what is live
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_FU; i++) begin
            if (push[i]) begin
                tag_mem[i][wr_ptr[i]]   <= bus.fu_tag_in[i*8 +: 8];
                value_mem[i][wr_ptr[i]] <= bus.fu_value_in[i*DATA_WIDTH +: DATA_WIDTH];
                misp_mem[i][wr_ptr[i]]  <= bus.fu_mispredicted_in[i];
            end
        end
    end

    // Stage p1: registered broadcast slots, null whenever ungranted or squashed
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus.cdb1_tag_out          <= RSTAG_NULL;
            bus.cdb1_value_out        <= '0;
            bus.cdb1_mispredicted_out <= 1'b0;
            bus.cdb2_tag_out          <= RSTAG_NULL;
            bus.cdb2_value_out        <= '0;
            bus.cdb2_mispredicted_out <= 1'b0;
        end else begin
            if (vld1_p0 && !bus.flush_in) begin
                bus.cdb1_tag_out          <= tag_mem[idx1_p0][rd_ptr[idx1_p0]];
                bus.cdb1_value_out        <= value_mem[idx1_p0][rd_ptr[idx1_p0]];
                bus.cdb1_mispredicted_out <= misp_mem[idx1_p0][rd_ptr[idx1_p0]];
            end else begin
                bus.cdb1_tag_out          <= RSTAG_NULL;
                bus.cdb1_value_out        <= '0;
                bus.cdb1_mispredicted_out <= 1'b0;
            end
            if (vld2_p0 && !bus.flush_in) begin
                bus.cdb2_tag_out          <= tag_mem[idx2_p0][rd_ptr[idx2_p0]];
                bus.cdb2_value_out        <= value_mem[idx2_p0][rd_ptr[idx2_p0]];
                bus.cdb2_mispredicted_out <= misp_mem[idx2_p0][rd_ptr[idx2_p0]];
            end else begin
                bus.cdb2_tag_out          <= RSTAG_NULL;
                bus.cdb2_value_out        <= '0;
                bus.cdb2_mispredicted_out <= 1'b0;
            end
        end
    end

    // The null tag is reserved for idle slots, so no FU may ever hand it in
    for (genvar g = 0; g < NUM_FU; g++) begin : g_tag_chk
        assert property (@(posedge clock) disable iff (!reset)
            push[g] |-> (bus.fu_tag_in[g*8 +: 8] != RSTAG_NULL));
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized scoreboard bench for cdb_arbiter against a queue-based reference model.
module tb_cdb_arbiter;
    localparam int NUM_FU = 4;
    localparam int QDEPTH = 2;
    localparam int DW     = 32;

    typedef struct packed {
        logic [7:0]    tag;
        logic [DW-1:0] val;
        logic          misp;
    } res_t;

    typedef struct packed {
        res_t s1;
        res_t s2;
    } pair_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    cdb_arbiter_if #(.NUM_FU(NUM_FU), .DATA_WIDTH(DW)) bus ();

    cdb_arbiter #(
        .NUM_FU(NUM_FU), .QDEPTH(QDEPTH), .DATA_WIDTH(DW), .RSTAG_NULL(8'hFF)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    res_t              pend  [NUM_FU];
    logic [NUM_FU-1:0] pvld  = '0;
    logic [NUM_FU-1:0] acc   = '0;
    logic              flush = 1'b0;
    res_t              dir_q [NUM_FU][$];

    res_t              mq    [NUM_FU][$];
    int                rr    = 0;
    pair_t             exp_q [$];
    bit                saw_full0 = 1'b0;

    pair_t             mdl_e;
    res_t              mdl_item;
    int                mdl_n;
    int                mdl_f;
    int                mdl_last;
    pair_t             mon_e;
    pair_t             mon_got;
    logic [NUM_FU-1:0] mon_rdy;

    function automatic res_t null_res();
        res_t r;
        r.tag  = 8'hFF;
        r.val  = '0;
        r.misp = 1'b0;
        return r;
    endfunction

    // Reference model: per-FU queues, two grants per cycle scanned from the round-robin start
    always @(posedge clock) begin
        if (reset) begin
            mdl_e.s1 = null_res();
            mdl_e.s2 = null_res();
            for (int i = 0; i < NUM_FU; i++)
                acc[i] = bus.fu_valid_in[i] && (mq[i].size() < QDEPTH);
            if (bus.flush_in) begin
                for (int i = 0; i < NUM_FU; i++) mq[i].delete();
                rr = 0;
            end else begin
                mdl_n    = 0;
                mdl_last = 0;
                for (int k = 0; k < NUM_FU; k++) begin
                    mdl_f = (rr + k) % NUM_FU;
                    if (mdl_n < 2 && mq[mdl_f].size() > 0) begin
                        if (mdl_n == 0) mdl_e.s1 = mq[mdl_f].pop_front();
                        else            mdl_e.s2 = mq[mdl_f].pop_front();
                        mdl_last = mdl_f;
                        mdl_n++;
                    end
                end
                if (mdl_n > 0) rr = (mdl_last + 1) % NUM_FU;
                for (int i = 0; i < NUM_FU; i++) begin
                    if (acc[i]) begin
                        mdl_item.tag  = bus.fu_tag_in[i*8 +: 8];
                        mdl_item.val  = bus.fu_value_in[i*DW +: DW];
                        mdl_item.misp = bus.fu_mispredicted_in[i];
                        mq[i].push_back(mdl_item);
                    end
                end
            end
            exp_q.push_back(mdl_e);
        end else begin
            acc = '0;
        end
    end

    always @(negedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_FU; i++) mon_rdy[i] = (mq[i].size() < QDEPTH);
            checks++;
            if (bus.fu_ready_out !== mon_rdy) begin
                errors++;
                $display("FAIL ready t=%0t: got %b want %b", $time, bus.fu_ready_out, mon_rdy);
            end
            if (!bus.fu_ready_out[0]) saw_full0 = 1'b1;
            mon_got.s1.tag  = bus.cdb1_tag_out;
            mon_got.s1.val  = bus.cdb1_value_out;
            mon_got.s1.misp = bus.cdb1_mispredicted_out;
            mon_got.s2.tag  = bus.cdb2_tag_out;
            mon_got.s2.val  = bus.cdb2_value_out;
            mon_got.s2.misp = bus.cdb2_mispredicted_out;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL cdb t=%0t: got %h/%h no expectation queued", $time,
                         mon_got.s1.tag, mon_got.s2.tag);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_got !== mon_e) begin
                    errors++;
                    $display("FAIL cdb t=%0t: got s1=%h/%h/%b s2=%h/%h/%b want s1=%h/%h/%b s2=%h/%h/%b",
                             $time, mon_got.s1.tag, mon_got.s1.val, mon_got.s1.misp,
                             mon_got.s2.tag, mon_got.s2.val, mon_got.s2.misp,
                             mon_e.s1.tag, mon_e.s1.val, mon_e.s1.misp,
                             mon_e.s2.tag, mon_e.s2.val, mon_e.s2.misp);
                end
            end
        end
    end

    task automatic apply();
        for (int i = 0; i < NUM_FU; i++) begin
            bus.fu_tag_in[i*8 +: 8]   = pend[i].tag;
            bus.fu_value_in[i*DW +: DW] = pend[i].val;
            bus.fu_mispredicted_in[i] = pend[i].misp;
        end
        bus.fu_valid_in = pvld;
        bus.flush_in    = flush;
    endtask

    // One cycle of FU behaviour: retire accepted items, then offer queued or random ones
    task automatic step(input int prob, input bit fixed_tag, input bit fl);
        @(negedge clock);
        #1;
        for (int i = 0; i < NUM_FU; i++) begin
            if (pvld[i] && acc[i]) pvld[i] = 1'b0;
            if (!pvld[i]) begin
                if (dir_q[i].size() > 0) begin
                    pend[i] = dir_q[i].pop_front();
                    pvld[i] = 1'b1;
                end else if ($urandom_range(99) < prob) begin
                    pend[i].tag  = fixed_tag ? 8'(i) : 8'($urandom_range(254));
                    pend[i].val  = $urandom;
                    pend[i].misp = 1'($urandom_range(1));
                    pvld[i] = 1'b1;
                end
            end
        end
        flush = fl;
        apply();
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic check_reset_state(input string tagname);
        chk({tagname, "_cdb1_tag"},  64'(bus.cdb1_tag_out), 64'hFF);
        chk({tagname, "_cdb1_val"},  64'(bus.cdb1_value_out), 64'h0);
        chk({tagname, "_cdb1_misp"}, 64'(bus.cdb1_mispredicted_out), 64'h0);
        chk({tagname, "_cdb2_tag"},  64'(bus.cdb2_tag_out), 64'hFF);
        chk({tagname, "_cdb2_val"},  64'(bus.cdb2_value_out), 64'h0);
        chk({tagname, "_cdb2_misp"}, 64'(bus.cdb2_mispredicted_out), 64'h0);
        chk({tagname, "_ready"},     64'(bus.fu_ready_out), 64'hF);
    endtask

    function automatic res_t mk(input logic [7:0] t, input logic [DW-1:0] v, input logic m);
        res_t r;
        r.tag  = t;
        r.val  = v;
        r.misp = m;
        return r;
    endfunction

    initial begin
        for (int i = 0; i < NUM_FU; i++) pend[i] = null_res();
        apply();
        #1 reset = 1'b0;
        #2 check_reset_state("por");
        @(negedge clock);
        #2 reset = 1'b1;

        repeat (3) step(0, 1'b0, 1'b0);
        dir_q[2].push_back(mk(8'h05, 32'hDEAD, 1'b0));
        repeat (8) step(0, 1'b0, 1'b0);

        repeat (30) step(100, 1'b1, 1'b0);
        repeat (8) step(0, 1'b0, 1'b0);

        dir_q[0].push_back(mk(8'h40, 32'h1111_0000, 1'b0));
        dir_q[0].push_back(mk(8'h41, 32'h2222_0000, 1'b1));
        dir_q[0].push_back(mk(8'h42, 32'h3333_0000, 1'b0));
        repeat (20) step(100, 1'b0, 1'b0);
        repeat (10) step(0, 1'b0, 1'b0);
        chk("fu0_backpressure_seen", 64'(saw_full0), 64'h1);

        repeat (6) step(100, 1'b0, 1'b0);
        step(100, 1'b0, 1'b1);
        repeat (8) step(0, 1'b0, 1'b0);

        dir_q[3].push_back(mk(8'h1F, 32'hCAFE_F00D, 1'b1));
        dir_q[1].push_back(mk(8'h20, 32'h0BAD_0001, 1'b0));
        repeat (8) step(0, 1'b0, 1'b0);

        for (int n = 0; n < 600; n++)
            step(50, 1'b0, ($urandom_range(39) == 0));

        repeat (5) step(100, 1'b0, 1'b0);
        @(negedge clock);
        pvld  = '0;
        flush = 1'b0;
        apply();
        #2 reset = 1'b0;
        #1 check_reset_state("mid");
        for (int i = 0; i < NUM_FU; i++) begin
            mq[i].delete();
            dir_q[i].delete();
        end
        rr = 0;
        exp_q.delete();
        repeat (2) @(negedge clock);
        #2 reset = 1'b1;

        for (int n = 0; n < 200; n++)
            step(70, 1'b0, ($urandom_range(49) == 0));
        repeat (12) step(0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
